host_io_seq: RTL and testbench
==============================

Name: host_io_seq

Overview:
- Host-side sequencer that sits directly upstream of top_level and feeds it.
- Accepts a 16-bit operand X over a valid/ready handshake and writes X_lo/X_hi into data memory. It also clears Y_lo/Y_hi, pulses cpu_start, and waits for cpu_done.
- It then reads back the 16-bit result Y and returns it over a second valid/ready handshake.
- Replaces testbench back-door memory pokes with a synthesizable load/run/unload path.

Parameters:
- X_LO_ADDR, 8'h00, data-memory address of X low byte
- X_HI_ADDR, 8'h01, data-memory address of X high byte
- Y_LO_ADDR, 8'h02, data-memory address of Y low byte
- Y_HI_ADDR, 8'h03, data-memory address of Y high byte
- TIMEOUT_CYCLES, 1000, maximum cycles spent waiting for cpu_done
- CNT_W, 10, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  host operand valid
- in_ready  out  1  block can accept an operand
- in_x  in  16  operand X; [15:8]=X_hi, [7:0]=X_lo
- out_valid  out  1  result valid
- out_ready  in  1  host accepts result
- out_y  out  16  result Y; [15:8]=Y_hi, [7:0]=Y_lo
- out_err  out  1  result invalid because of timeout; qualified by out_valid
- mem_we  out  1  data-memory write enable
- mem_addr  out  8  data-memory address
- mem_wdata  out  8  data-memory write data
- mem_rdata  in  8  data-memory read data; asynchronous read, valid in the same cycle as mem_addr
- cpu_start  out  1  one-cycle start pulse to the core
- cpu_done  in  1  core done; level signal, stays high until the next start
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - reset is asynchronous, active-high; clock is clk.
  - On reset: state=IDLE; in_ready=1; out_valid=0; out_err=0; out_y=0; mem_we=0; mem_addr=0; mem_wdata=0; cpu_start=0; busy=0; timeout counter=0.
- All outputs are registered or decoded from state only. No combinational path from in_valid/out_ready to any output.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_x and go to WR_XLO.
  - WR_XLO: mem_we=1, addr=X_LO_ADDR, wdata=x[7:0]. Next: WR_XHI.
  - WR_XHI: mem_we=1, addr=X_HI_ADDR, wdata=x[15:8]. Next: CLR_YLO.
  - CLR_YLO: mem_we=1, addr=Y_LO_ADDR, wdata=0. Next: CLR_YHI.
  - CLR_YHI: mem_we=1, addr=Y_HI_ADDR, wdata=0. Next: START.
  - START: cpu_start=1 for exactly this cycle; counter cleared. Next: ARM.
  - ARM: wait for cpu_done==0, discarding a stale done from the previous run. Counter increments. Next: WAIT_DONE.
  - WAIT_DONE: wait for cpu_done==1, then go to RD_YLO. Counter keeps incrementing.
  - Timeout, from ARM or WAIT_DONE: if counter reaches TIMEOUT_CYCLES-1 without the exit condition, go to OUT with out_err=1 and out_y=16'h0000. The read-back states are skipped.
  - RD_YLO: addr=Y_LO_ADDR, mem_we=0; capture mem_rdata into y[7:0]. Next: RD_YHI.
  - RD_YHI: addr=Y_HI_ADDR; capture into y[15:8]. Next: OUT.
  - OUT: out_valid=1; out_y and out_err held stable. On out_ready, go to IDLE; out_valid drops next cycle and in_ready rises next cycle.
- Latency:
  - Input handshake at cycle 0 gives writes in cycles 1-4 and cpu_start in cycle 5.
  - If cpu_done is first seen high at cycle N, reads happen at N+1 and N+2, and out_valid rises at N+3.
- Boundaries:
  - in_valid outside IDLE is ignored because in_ready=0.
  - out_ready outside OUT has no effect.
  - If cpu_done is already 0 in ARM, the block spends exactly one cycle there.
  - If done rises in the same cycle the counter hits its limit, done wins; this is not a timeout.
  - Reset mid-operation returns to IDLE immediately. A write in flight is aborted (mem_we drops asynchronously) and no further cpu_start is issued.
  - out_err=1 only on timeout; it is cleared at the next input handshake.

Decomposition:
- Package host_io_pkg:
  - state_t enum: IDLE, WR_XLO, WR_XHI, CLR_YLO, CLR_YHI, START, ARM, WAIT_DONE, RD_YLO, RD_YHI, OUT.
  - Default address constants.
- Single module, no sub-module. The timeout counter is inline.

Test Plan:
- Nominal run:
  - Stimulus: in_x=16'h0300 (3.0). Model core drops done 1 cycle after start and raises it 20 cycles later with mem[2]=8'hBB, mem[3]=8'hAA.
  - Required: writes mem[0]=00, mem[1]=03, mem[2]=00, mem[3]=00 in cycles 1-4; one cpu_start pulse at cycle 5; out_y=16'hAABB with out_err=0.
- Stale done:
  - Stimulus: cpu_done held high into START, falls 3 cycles later, rises after 10 more.
  - Required: no early read-back; out_valid appears 3 cycles after the rise.
- Timeout:
  - Stimulus: cpu_done never rises, TIMEOUT_CYCLES=16.
  - Required: out_valid with out_err=1 and out_y=0 after 16 wait cycles; no memory reads issued.
- Backpressure:
  - Stimulus: out_ready held low for 7 cycles in OUT, and in_valid pulsed during that window.
  - Required: out_y stable; in_ready=0 and the new operand is not accepted; IDLE is entered the cycle after out_ready=1.
- Reset mid-write:
  - Stimulus: assert reset during WR_XHI.
  - Required: mem_we=0 immediately; all outputs at reset values; no cpu_start pulse; a new operand is accepted normally afterward.
- Back-to-back:
  - Stimulus: two operands 16'h0100 and 16'h0200, out_ready tied high.
  - Required: two results in order; exactly two cpu_start pulses; in_ready reasserts one cycle after each out handshake.

Source files
------------

// File: rtl/host_io_pkg.sv
// Shared types and default addresses for the host load/run/unload sequencer.
// Sequencer states are listed in the order a normal transaction visits them.
package host_io_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_XLO,
    WR_XHI,
    CLR_YLO,
    CLR_YHI,
    START,
    ARM,
    WAIT_DONE,
    RD_YLO,
    RD_YHI,
    OUT
  } state_t;

  localparam logic [7:0] X_LO_ADDR_DEF      = 8'h00;
  localparam logic [7:0] X_HI_ADDR_DEF      = 8'h01;
  localparam logic [7:0] Y_LO_ADDR_DEF      = 8'h02;
  localparam logic [7:0] Y_HI_ADDR_DEF      = 8'h03;
  localparam int         TIMEOUT_CYCLES_DEF = 1000;
  localparam int         CNT_W_DEF          = 10;

endpackage

// File: rtl/host_io_seq.sv
// Host-side sequencer: loads operand X into data memory, starts the core,
// waits for done (with timeout) and returns result Y over a valid/ready port.
module host_io_seq
  import host_io_pkg::*;
#(
  parameter logic [7:0] X_LO_ADDR      = X_LO_ADDR_DEF,
  parameter logic [7:0] X_HI_ADDR      = X_HI_ADDR_DEF,
  parameter logic [7:0] Y_LO_ADDR      = Y_LO_ADDR_DEF,
  parameter logic [7:0] Y_HI_ADDR      = Y_HI_ADDR_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int         CNT_W          = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_y,
  output logic        out_err,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_start,
  input  logic        cpu_done,
  output logic        busy
);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_x;
  logic [15:0]      r_y;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_limit;

  assign w_limit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign out_y   = r_y;
  assign out_err = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Outputs decode from state only; the handshake inputs affect next state alone.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    cpu_start = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = WR_XLO;
      end
      WR_XLO: begin
        mem_we    = 1'b1;
        mem_addr  = X_LO_ADDR;
        mem_wdata = r_x[7:0];
        w_next    = WR_XHI;
      end
      WR_XHI: begin
        mem_we    = 1'b1;
        mem_addr  = X_HI_ADDR;
        mem_wdata = r_x[15:8];
        w_next    = CLR_YLO;
      end
      CLR_YLO: begin
        mem_we   = 1'b1;
        mem_addr = Y_LO_ADDR;
        w_next   = CLR_YHI;
      end
      CLR_YHI: begin
        mem_we   = 1'b1;
        mem_addr = Y_HI_ADDR;
        w_next   = START;
      end
      START: begin
        cpu_start = 1'b1;
        w_next    = ARM;
      end
      // A done still high from the previous run must fall before we trust a rise.
      ARM: begin
        if (!cpu_done)    w_next = WAIT_DONE;
        else if (w_limit) w_next = OUT;
      end
      WAIT_DONE: begin
        if (cpu_done)     w_next = RD_YLO;
        else if (w_limit) w_next = OUT;
      end
      RD_YLO: begin
        mem_addr = Y_LO_ADDR;
        w_next   = RD_YHI;
      end
      RD_YHI: begin
        mem_addr = Y_HI_ADDR;
        w_next   = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) r_x <= in_x;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y   <= 16'h0000;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE:   if (in_valid) r_err <= 1'b0;
        START:  r_cnt <= '0;
        ARM, WAIT_DONE: begin
          r_cnt <= r_cnt + 1'b1;
          // Leaving the wait straight to OUT means the limit expired.
          if (w_next == OUT) begin
            r_err <= 1'b1;
            r_y   <= 16'h0000;
          end
        end
        RD_YLO: r_y[7:0]  <= mem_rdata;
        RD_YHI: r_y[15:8] <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_host_io_seq.sv
// Bench for host_io_seq: a behavioural core/memory model, a driver that queues
// expected results, and a monitor that checks every result and handshake.
module tb_host_io_seq;

  localparam int TO   = 1000;
  localparam int TO_S = 16;

  typedef struct {
    logic [15:0] x;
    int          stale;
    int          dly;
    bit          hang;
    logic [15:0] res;
  } cfg_t;

  typedef struct {
    logic [15:0] y;
    bit          err;
    int          reads;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_x, out_y;
  logic        mem_we, cpu_start, cpu_done, busy;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  logic        t_in_valid, t_in_ready, t_ov, t_out_ready, t_err;
  logic [15:0] t_in_x, t_y;
  logic        t_we, t_start, t_done, t_busy;
  logic [7:0]  t_addr, t_wdata, t_rdata;

  logic [7:0]  mem [256];
  cfg_t        cfg_q[$];
  exp_t        exp_q[$];
  cfg_t        cur;
  int          ph, cnt;

  int cyc;
  int n_tests, n_fail;
  int n_issued, n_start;
  bit rst_chk, fin;
  int hs_cyc, start_cyc, done_cyc, reads;
  bit prev_ov, prev_done, expect_idle;
  logic [15:0] ov_y;
  logic        ov_err;
  int t_start_cyc, t_reads;
  bit t_prev_ov;
  int t_exp_lat, t_exp_reads;
  logic [15:0] t_exp_y;
  logic        t_exp_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  host_io_seq u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_start(cpu_start), .cpu_done(cpu_done), .busy(busy)
  );

  host_io_seq #(.TIMEOUT_CYCLES(TO_S), .CNT_W(5)) u_to (
    .clk(clk), .reset(reset),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_x(t_in_x),
    .out_valid(t_ov), .out_ready(t_out_ready), .out_y(t_y), .out_err(t_err),
    .mem_we(t_we), .mem_addr(t_addr), .mem_wdata(t_wdata), .mem_rdata(t_rdata),
    .cpu_start(t_start), .cpu_done(t_done), .busy(t_busy)
  );

  assign mem_rdata = mem[mem_addr];
  assign t_rdata   = t_addr ^ 8'hC3;

  // Core model: done falls 'stale' cycles after start, rises 'dly' later with the result.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (reset) begin
      ph       <= 0;
      cpu_done <= 1'b0;
    end else if (cpu_start && cfg_q.size() != 0) begin
      cur = cfg_q.pop_front();
      ph  <= 1;
      cnt <= cur.stale;
    end else if (ph == 1) begin
      if (cnt == 0) begin
        cpu_done <= 1'b0;
        ph       <= 2;
        cnt      <= cur.dly;
      end else cnt <= cnt - 1;
    end else if (ph == 2 && !cur.hang) begin
      if (cnt == 0) begin
        mem[2]   <= cur.res[7:0];
        mem[3]   <= cur.res[15:8];
        cpu_done <= 1'b1;
        ph       <= 0;
      end else cnt <= cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (rst_chk) begin
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_start", cpu_start, 0);
        chk("rst_busy", busy, 0);
      end
      prev_ov     = 1'b0;
      prev_done   = cpu_done;
      expect_idle = 1'b0;
      t_prev_ov   = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
      end
      expect_idle = 1'b0;
      if (cpu_done && !prev_done) done_cyc = cyc;
      prev_done = cpu_done;
      if (busy && !mem_we && (mem_addr == 8'h02 || mem_addr == 8'h03)) reads++;
      if (cpu_start) begin
        n_start++;
        start_cyc = cyc;
        chk("start_expected", cfg_q.size() != 0, 1);
        if (cfg_q.size() != 0) begin
          chk("start_latency", cyc - hs_cyc, 5);
          chk("mem_x_lo", mem[0], cfg_q[0].x[7:0]);
          chk("mem_x_hi", mem[1], cfg_q[0].x[15:8]);
          chk("mem_y_lo_clr", mem[2], 0);
          chk("mem_y_hi_clr", mem[3], 0);
        end
      end
      if (out_valid) begin
        chk("out_in_ready_low", in_ready, 0);
        if (!prev_ov) begin
          ov_y   = out_y;
          ov_err = out_err;
          chk("out_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            chk("out_y", out_y, exp_q[0].y);
            chk("out_err", out_err, exp_q[0].err);
            chk("read_count", reads, exp_q[0].reads);
            if (exp_q[0].err) chk("timeout_latency", cyc - start_cyc, TO + 1);
            else              chk("done_latency", cyc - done_cyc, 3);
          end
        end else begin
          chk("out_y_stable", out_y, ov_y);
          chk("out_err_stable", out_err, ov_err);
        end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          expect_idle = 1'b1;
        end
      end
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        hs_cyc = cyc;
        reads  = 0;
      end

      if (t_start) t_start_cyc = cyc;
      if (t_busy && !t_we && (t_addr == 8'h02 || t_addr == 8'h03)) t_reads++;
      if (t_ov && !t_prev_ov) begin
        chk("small_latency", cyc - t_start_cyc, t_exp_lat);
        chk("small_out_y", t_y, t_exp_y);
        chk("small_out_err", t_err, t_exp_err);
        chk("small_reads", t_reads, t_exp_reads);
      end
      t_prev_ov = t_ov;
      if (t_in_valid && t_in_ready) t_reads = 0;
    end
    if (fin) begin
      chk("start_count", n_start, n_issued);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the result handshake.
  task automatic run_txn(input logic [15:0] x, input int stale, input int dly, input bit hang,
                         input logic [15:0] res, input int bp, input bit poke);
    cfg_t c;
    exp_t e;
    int   n;
    c.x = x; c.stale = stale; c.dly = dly; c.hang = hang; c.res = res;
    e.y = hang ? 16'h0000 : res;
    e.err = hang;
    e.reads = hang ? 0 : 2;
    cfg_q.push_back(c);
    exp_q.push_back(e);
    n_issued++;
    in_valid = 1'b1;
    in_x     = x;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) begin
      $display("FAIL in_handshake_timeout: in_ready never rose");
      $fatal(1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_x      = 16'($urandom);
    out_ready = (bp == 0);
    n = 0;
    while (!out_valid && n < TO + 200) begin @(negedge clk); n++; end
    if (!out_valid) begin
      $display("FAIL out_valid_timeout: no result within %0d cycles", n);
      $fatal(1);
    end
    if (bp > 0) begin
      repeat (bp) begin
        @(posedge clk); #1;
        if (poke) begin
          in_valid = 1'($urandom_range(0, 1));
          in_x     = 16'($urandom);
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic small_wait();
    int n;
    n = 0;
    while (!t_ov && n < 100) begin @(negedge clk); n++; end
    if (!t_ov) begin
      $display("FAIL small_out_timeout: no result from short-timeout instance");
      $fatal(1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; rst_chk = 1'b1; fin = 1'b0;
    in_valid = 1'b0; in_x = 16'h0; out_ready = 1'b0;
    t_in_valid = 1'b0; t_in_x = 16'h0; t_out_ready = 1'b0; t_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; rst_chk = 1'b0;
    @(posedge clk); #1;

    run_txn(16'h0300, 0, 20, 1'b0, 16'hAABB, 0, 1'b0);
    run_txn(16'h1234, 3, 10, 1'b0, 16'h5A3C, 0, 1'b0);
    run_txn(16'hBEEF, 0, 5, 1'b0, 16'h0F0F, 7, 1'b1);
    run_txn(16'h7777, 0, 0, 1'b1, 16'hFFFF, 2, 1'b0);
    run_txn(16'h0100, 0, 4, 1'b0, 16'h1111, 0, 1'b0);
    run_txn(16'h0200, 2, 6, 1'b0, 16'h2222, 0, 1'b0);

    // Async reset while WR_XHI is driving the bus.
    in_valid = 1'b1; in_x = 16'h4321;
    @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1; rst_chk = 1'b1;
    @(posedge clk); #1 reset = 1'b0; rst_chk = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    run_txn(16'h0055, 1, 3, 1'b0, 16'hC3A5, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      run_txn(16'($urandom), $urandom_range(0, 4), $urandom_range(0, 25),
              ($urandom_range(0, 11) == 0), 16'($urandom), $urandom_range(0, 4),
              1'($urandom_range(0, 1)));
    end

    // Short-timeout instance: done never comes.
    t_exp_lat = TO_S + 1; t_exp_y = 16'h0000; t_exp_err = 1'b1; t_exp_reads = 0;
    t_out_ready = 1'b1; t_in_valid = 1'b1; t_in_x = 16'h0A0B;
    @(negedge clk);
    @(posedge clk); #1 t_in_valid = 1'b0;
    small_wait();

    // Done arrives on the last allowed wait cycle: it wins over the timeout.
    t_exp_lat = TO_S + 3; t_exp_y = 16'hC0C1; t_exp_err = 1'b0; t_exp_reads = 2;
    t_in_valid = 1'b1; t_in_x = 16'h0C0D;
    @(negedge clk);
    @(posedge clk); #1 t_in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 t_done = 1'b1;
    small_wait();
    t_done = 1'b0;

    repeat (3) @(posedge clk);
    fin = 1'b1;
  end

endmodule
